fetch_unit: RTL and testbench

Instruction fetch stage for the MIPS core. Owns the program counter, issues word reads to instruction memory over a req/ack handshake, and holds the fetched word in the IF/ID register. Exports the opcode field `op_o` to the control decoder. Takes jump and taken-branch redirects back from decode and flushes wrong-path instructions.

---
 rtl/fetch_unit.sv | 136 +++++++++++++
 tb/tb_fetch_unit.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: MIPS instruction fetch stage. Owns the PC, reads imem over req/ack, holds IF/ID.
// Ports: clk_i/rst_i (sync, active-high), start_i, stall_i, jump_i, branch_taken_i, target_i,
//   imem_req_o/imem_addr_o/imem_ack_i/imem_rdata_i, instr_o, op_o, pc_plus4_o, valid_o.
// Optional FETCH_PERF_CNT_EN adds fetch_cnt_o (captured words) and bubble_cnt_o (running bubbles).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        jump_i,
  input  logic        branch_taken_i,
  input  logic [31:0] target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic [5:0]  op_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] bubble_cnt_o
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, DROP} state_t;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic [31:0] tgt, tgt_nx;
  logic [31:0] tgt_in, pc_inc;
  logic        pend, pend_nx;
  logic        redirect, slot_free;
  logic        done, capture;

  assign redirect    = jump_i | branch_taken_i;
  assign slot_free   = !valid_o | !stall_i;
  assign tgt_in      = target_i & ~32'h3;
  assign pc_inc      = pc + 32'd4;
  assign imem_addr_o = pc;
  assign op_o        = instr_o[31:26];
  assign done        = imem_req_o & imem_ack_i;

  // pend marks a request already presented without ack; it
  // keeps req high and the address frozen until memory answers.
  always_comb begin
    state_nx   = state;
    pc_nx      = pc;
    tgt_nx     = tgt;
    pend_nx    = pend;
    imem_req_o = 1'b0;
    capture    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_i) state_nx = FETCH;
      end
      FETCH: begin
        imem_req_o = pend | slot_free;
        if (done) begin
          pend_nx = 1'b0;
          if (redirect) begin
            pc_nx = tgt_in;
          end else begin
            pc_nx   = pc_inc;
            capture = 1'b1;
          end
        end else if (imem_req_o) begin
          pend_nx = 1'b1;
          if (redirect) begin
            tgt_nx   = tgt_in;
            state_nx = DROP;
          end
        end else if (redirect) begin
          pc_nx = tgt_in;
        end
      end
      DROP: begin
        imem_req_o = 1'b1;
        if (redirect) tgt_nx = tgt_in;
        if (imem_ack_i) begin
          pend_nx  = 1'b0;
          pc_nx    = redirect ? tgt_in : tgt;
          state_nx = FETCH;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      pc    <= RESET_PC;
      tgt   <= 32'h0;
      pend  <= 1'b0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      tgt   <= tgt_nx;
      pend  <= pend_nx;
    end
  end

  // IF/ID: capture, else redirect/no-stall drops to a bubble, else hold.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o    <= 1'b0;
      instr_o    <= 32'h0;
      pc_plus4_o <= 32'h0;
    end else if (capture) begin
      valid_o    <= 1'b1;
      instr_o    <= imem_rdata_i;
      pc_plus4_o <= pc_inc;
    end else if (redirect || !stall_i) begin
      valid_o    <= 1'b0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_cnt_o  <= 32'h0;
      bubble_cnt_o <= 32'h0;
    end else begin
      if (capture) fetch_cnt_o <= fetch_cnt_o + 32'd1;
      if (state != IDLE && !valid_o)
        bubble_cnt_o <= bubble_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a transaction-level
// reference model checked every cycle plus literal spot checks.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, start, stall, jump, br;
  logic [31:0] target;
  logic        req, ack;
  logic [31:0] addr, rdata, instr, pp4;
  logic [5:0]  op;
  logic        valid;

  logic        req2, valid2;
  logic [31:0] addr2, instr2, pp4_2, rdata2;
  logic [5:0]  op2;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fcnt, bcnt, fcnt2, bcnt2;
`endif

  int          mem_wait = 0;
  int          wcnt = 0;
  logic        ack_force = 1'b0;
  logic        s_req, s_ack, s_rst;

  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] data(input logic [31:0] a);
    if (a == 32'h10) return 32'h8C22_0004;
    return {a[7:2], a[25:0]};
  endfunction

  // memory: ack once the request has waited mem_wait cycles
  assign ack    = (req && (wcnt >= mem_wait)) || ack_force;
  assign rdata  = data(addr);
  assign rdata2 = data(addr2);

  fetch_unit u_dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .stall_i        (stall),
    .jump_i         (jump),
    .branch_taken_i (br),
    .target_i       (target),
    .imem_req_o     (req),
    .imem_addr_o    (addr),
    .imem_ack_i     (ack),
    .imem_rdata_i   (rdata),
    .instr_o        (instr),
    .op_o           (op),
    .pc_plus4_o     (pp4),
    .valid_o        (valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt_o    (fcnt),
    .bubble_cnt_o   (bcnt)
`endif
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .stall_i        (1'b0),
    .jump_i         (1'b0),
    .branch_taken_i (1'b0),
    .target_i       (32'h0),
    .imem_req_o     (req2),
    .imem_addr_o    (addr2),
    .imem_ack_i     (req2),
    .imem_rdata_i   (rdata2),
    .instr_o        (instr2),
    .op_o           (op2),
    .pc_plus4_o     (pp4_2),
    .valid_o        (valid2)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt_o    (fcnt2),
    .bubble_cnt_o   (bcnt2)
`endif
  );

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (s_rst || !(s_req && !s_ack)) wcnt = 0;
    else wcnt = wcnt + 1;
  end

  // reference model: what the fetch stage should be doing
  logic        chk_en = 1'b0;
  logic        m_run, m_drop, m_busy;
  logic [31:0] m_fpc, m_dpc;
  logic        e_valid, e_req, redir, got;
  logic [31:0] e_instr, e_pp4, tg;
  logic [31:0] m_fcnt, m_bcnt;

  always @(negedge clk) begin
    e_req = m_run && (m_drop || m_busy || !e_valid || !stall);
    if (chk_en) begin
      cmp("m_req", {31'b0, req}, {31'b0, e_req});
      if (e_req) cmp("m_addr", addr, m_fpc);
      cmp("m_valid", {31'b0, valid}, {31'b0, e_valid});
      cmp("m_instr", instr, e_instr);
      cmp("m_op", {26'b0, op}, {26'b0, e_instr[31:26]});
      cmp("m_pc4", pp4, e_pp4);
`ifdef FETCH_PERF_CNT_EN
      cmp("m_fcnt", fcnt, m_fcnt);
      cmp("m_bcnt", bcnt, m_bcnt);
`endif
    end
    s_req = req;
    s_ack = ack;
    s_rst = rst;
    if (rst) begin
      m_run = 0; m_drop = 0; m_busy = 0;
      m_fpc = 32'h0; m_dpc = 32'h0;
      e_valid = 0; e_instr = 0; e_pp4 = 0;
      m_fcnt = 0; m_bcnt = 0;
      chk_en = 1'b1;
    end else begin
      redir = jump | br;
      tg    = target & ~32'h3;
      got   = e_req && ack;
      if (m_run && !e_valid) m_bcnt = m_bcnt + 1;
      if (!m_run) begin
        if (start) m_run = 1;
      end else if (m_drop) begin
        if (redir) m_dpc = tg;
        if (got) begin
          m_drop = 0; m_busy = 0; m_fpc = m_dpc;
        end
        if (redir || !stall) e_valid = 0;
      end else if (got && !redir) begin
        e_instr = rdata;
        e_pp4   = m_fpc + 32'd4;
        e_valid = 1;
        m_fpc   = m_fpc + 32'd4;
        m_busy  = 0;
        m_fcnt  = m_fcnt + 1;
      end else begin
        if (got) begin
          m_fpc = tg; m_busy = 0;
        end else if (e_req && redir) begin
          m_drop = 1; m_busy = 1; m_dpc = tg;
        end else if (e_req) begin
          m_busy = 1;
        end else if (redir) begin
          m_fpc = tg;
        end
        if (redir || !stall) e_valid = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  initial begin
    rst = 1; start = 0; stall = 0; jump = 0; br = 0;
    target = 32'h0;
    tick(); tick();
    rst = 0;
    look();
    cmp("rst_req", {31'b0, req}, 32'h0);
    cmp("rst_valid", {31'b0, valid}, 32'h0);
    cmp("rst_instr", instr, 32'h0);
    cmp("rst_addr", addr, 32'h0);
    cmp("rst_addr2", addr2, 32'hFFFF_FFFC);
    tick();
    start = 1;
    tick();                                   // F1
    start = 0;
    look();
    cmp("f1_addr", addr, 32'h0);
    cmp("f1_req", {31'b0, req}, 32'h1);
    cmp("wrap_a0", addr2, 32'hFFFF_FFFC);
    tick();                                   // F2
    look();
    cmp("f2_addr", addr, 32'h4);
    cmp("f2_valid", {31'b0, valid}, 32'h1);
    cmp("wrap_a1", addr2, 32'h0);
    cmp("wrap_pc4", pp4_2, 32'h0);
    cmp("wrap_instr", instr2, 32'hFFFF_FFFC);
    tick();                                   // F3
    look();
    cmp("f3_instr", instr, 32'h0400_0004);
    cmp("f3_op", {26'b0, op}, 32'h1);
    cmp("f3_pc4", pp4, 32'h8);
    tick(); tick(); tick();                   // F6
    stall = 1;
    repeat (3) begin
      look();
      cmp("stl_instr", instr, 32'h8C22_0004);
      cmp("stl_op", {26'b0, op}, 32'h23);
      cmp("stl_req", {31'b0, req}, 32'h0);
      tick();
    end                                       // F9
    stall = 0;
    look();
    cmp("rel_addr", addr, 32'h14);
    tick();                                   // F10
    jump = 1;
    target = 32'h43;
    tick();                                   // F11
    jump = 0;
    look();
    cmp("jmp_valid", {31'b0, valid}, 32'h0);
    cmp("jmp_addr", addr, 32'h40);
    cmp("jmp_hold", instr, 32'h1400_0014);
    tick();                                   // F12
    mem_wait = 3;
    look();
    cmp("jmp_instr", instr, 32'h4000_0040);
    cmp("jmp_pc4", pp4, 32'h44);
    tick();                                   // F13
    br = 1;
    target = 32'h100;
    tick();                                   // F14
    br = 0;
    look();
    cmp("drp_addr", addr, 32'h44);
    cmp("drp_req", {31'b0, req}, 32'h1);
    tick();                                   // F15
    look();
    cmp("drp_addr2", addr, 32'h44);
    tick();                                   // F16
    mem_wait = 0;
    look();
    cmp("br_addr", addr, 32'h100);
    cmp("br_valid", {31'b0, valid}, 32'h0);
    tick();                                   // F17
    mem_wait = 2;
    look();
    cmp("br_instr", instr, 32'h0000_0100);
    tick();                                   // F18
    rst = 1;
    tick();                                   // F19
    rst = 0;
    ack_force = 1;
    look();
    cmp("mrst_req", {31'b0, req}, 32'h0);
    cmp("mrst_valid", {31'b0, valid}, 32'h0);
    cmp("mrst_addr", addr, 32'h0);
    tick();
    ack_force = 0;
    look();
    cmp("idle_ack", {31'b0, valid}, 32'h0);
    tick();
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 90; i++) begin
      stall    = (i % 7) >= 5;
      jump     = (i % 11) == 4;
      br       = (i % 13) == 9;
      target   = 32'h200 + i * 8 + (i % 4);
      mem_wait = (i / 20) % 3;
      tick();
    end
    stall = 0; jump = 0; br = 0; mem_wait = 0;
    rst = 1;
    tick(); tick();
    rst = 0;
    tick();
    start = 1;
    tick();                                   // P1
    start = 0;
    repeat (5) tick();                        // P6
    jump = 1;
    target = 32'h80;
    tick();                                   // P7
    jump = 0;
    tick();                                   // P8
    stall = 1;
    tick();                                   // P9
    tick();                                   // P10
    stall = 0;
    repeat (4) tick();                        // P14
    look();
    cmp("p_addr", addr, 32'h94);
`ifdef FETCH_PERF_CNT_EN
    cmp("p_fetch", fcnt, 32'd10);
    cmp("p_bubble", bcnt, 32'd2);
`endif
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
